// File: rtl/ub_writeback_deskew_if.sv
// Bundle for the staggered two-lane receive side and the UB pair-write port.
// The master drives the lanes and start; the slave (deskew block) drives the writes.
interface ub_writeback_deskew_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
);
  logic              start_in;
  logic [ADDR_W-1:0] base_addr_in;
  logic [ADDR_W-1:0] num_elems_in;
  logic [DATA_W-1:0] lane1_data_in;
  logic              lane1_valid_in;
  logic [DATA_W-1:0] lane2_data_in;
  logic              lane2_valid_in;
  logic [ADDR_W-1:0] wr_addr_out;
  logic [DATA_W-1:0] wr_data_1_out;
  logic [DATA_W-1:0] wr_data_2_out;
  logic              wr_valid_1_out;
  logic              wr_valid_2_out;
  logic              busy_out;
  logic              done_out;
  logic              err_out;

  modport master (
    output start_in, base_addr_in, num_elems_in,
    output lane1_data_in, lane1_valid_in,
    output lane2_data_in, lane2_valid_in,
    input  wr_addr_out, wr_data_1_out, wr_data_2_out,
    input  wr_valid_1_out, wr_valid_2_out,
    input  busy_out, done_out, err_out
  );

  modport slave (
    input  start_in, base_addr_in, num_elems_in,
    input  lane1_data_in, lane1_valid_in,
    input  lane2_data_in, lane2_valid_in,
    output wr_addr_out, wr_data_1_out, wr_data_2_out,
    output wr_valid_1_out, wr_valid_2_out,
    output busy_out, done_out, err_out
  );
endinterface

// File: rtl/ub_writeback_deskew.sv
// Re-pairs staggered systolic result lanes into address-explicit UB pair writes.
// Define WB_RELU_EN to clamp negative words to zero before the write registers.
module ub_writeback_deskew #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input logic                  clk,
  input logic                  rst,
  ub_writeback_deskew_if.slave bus
);
  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] base, base_d;
  logic [ADDR_W-1:0] left, left_d;
  logic [ADDR_W-1:0] pidx, pidx_d;
  logic [DATA_W-1:0] hold, hold_d;
  logic              hold_v, hold_v_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic [DATA_W-1:0] d1, d1_d;
  logic [DATA_W-1:0] d2, d2_d;
  logic              v1, v1_d;
  logic              v2, v2_d;
  logic              done, done_d;
  logic              err, err_d;
  logic              pair, flush;
  logic [ADDR_W-1:0] rem, slot;

  function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] w);
`ifdef WB_RELU_EN
    return w[DATA_W-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  assign slot  = base + {pidx[ADDR_W-2:0], 1'b0};
  assign pair  = bus.lane2_valid_in && hold_v;
  assign rem   = pair ? left - ADDR_W'(2) : left;
  // a held word with one element left is the odd tail: flush it on its own
  assign flush = hold_v && (left == ADDR_W'(1));

  always_comb begin
    state_d  = state;
    base_d   = base;
    left_d   = left;
    pidx_d   = pidx;
    hold_d   = hold;
    hold_v_d = hold_v;
    addr_d   = addr;
    d1_d     = d1;
    d2_d     = d2;
    v1_d     = 1'b0;
    v2_d     = 1'b0;
    done_d   = 1'b0;
    err_d    = err;
    unique case (state)
      IDLE: begin
        if (bus.start_in) begin
          err_d    = 1'b0;
          base_d   = bus.base_addr_in;
          left_d   = bus.num_elems_in;
          pidx_d   = '0;
          hold_v_d = 1'b0;
          if (bus.num_elems_in == '0) done_d = 1'b1;
          else state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (bus.start_in) err_d = 1'b1;
        if (flush) begin
          v1_d     = 1'b1;
          d1_d     = relu(hold);
          d2_d     = '0;
          addr_d   = slot;
          left_d   = '0;
          hold_v_d = 1'b0;
          if (bus.lane1_valid_in || bus.lane2_valid_in) err_d = 1'b1;
        end else begin
          if (bus.lane2_valid_in && !hold_v) err_d = 1'b1;
          if (pair) begin
            v1_d     = 1'b1;
            v2_d     = 1'b1;
            d1_d     = relu(hold);
            d2_d     = relu(bus.lane2_data_in);
            addr_d   = slot;
            pidx_d   = pidx + ADDR_W'(1);
            hold_v_d = 1'b0;
            left_d   = rem;
          end
          if (bus.lane1_valid_in) begin
            if ((hold_v && !pair) || rem == '0) begin
              err_d = 1'b1;
            end else if (rem == ADDR_W'(1) && !pair) begin
              v1_d   = 1'b1;
              d1_d   = relu(bus.lane1_data_in);
              d2_d   = '0;
              addr_d = slot;
              left_d = '0;
            end else begin
              hold_d   = bus.lane1_data_in;
              hold_v_d = 1'b1;
            end
          end
        end
        if (left_d == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      base   <= '0;
      left   <= '0;
      pidx   <= '0;
      hold   <= '0;
      hold_v <= 1'b0;
      addr   <= '0;
      d1     <= '0;
      d2     <= '0;
      v1     <= 1'b0;
      v2     <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_d;
      base   <= base_d;
      left   <= left_d;
      pidx   <= pidx_d;
      hold   <= hold_d;
      hold_v <= hold_v_d;
      addr   <= addr_d;
      d1     <= d1_d;
      d2     <= d2_d;
      v1     <= v1_d;
      v2     <= v2_d;
      done   <= done_d;
      err    <= err_d;
    end
  end

  assign bus.wr_addr_out    = addr;
  assign bus.wr_data_1_out  = d1;
  assign bus.wr_data_2_out  = d2;
  assign bus.wr_valid_1_out = v1;
  assign bus.wr_valid_2_out = v2;
  assign bus.busy_out       = (state == ACTIVE);
  assign bus.done_out       = done;
  assign bus.err_out        = err;
endmodule

// File: tb/tb_ub_writeback_deskew.sv
// Directed and randomized bench for ub_writeback_deskew.
// Expected writes come from the element list, base and count alone.
module tb_ub_writeback_deskew;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  typedef struct packed {
    logic [5:0]  a;
    logic [15:0] d1;
    logic [15:0] d2;
    logic        v2;
    logic        dn;
  } wr_t;

  wr_t q[$];
  logic [15:0] el[16];
  logic [15:0] A = 16'h1111, B = 16'h2222, C = 16'h3333, D = 16'h4444;

  ub_writeback_deskew_if #(.DATA_W(16), .ADDR_W(6)) bus ();

  ub_writeback_deskew #(.DATA_W(16), .ADDR_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.wr_valid_1_out || bus.wr_valid_2_out)
      q.push_back('{bus.wr_addr_out, bus.wr_data_1_out,
                    bus.wr_data_2_out, bus.wr_valid_2_out, bus.done_out});
    if (bus.done_out) done_cnt++;
  end

  function automatic logic [15:0] rl(input logic [15:0] w);
`ifdef WB_RELU_EN
    return (w >= 16'h8000) ? 16'h0000 : w;
`else
    return w;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic l1v, input logic [15:0] l1d,
                      input logic l2v, input logic [15:0] l2d);
    bus.lane1_valid_in = l1v;
    bus.lane1_data_in  = l1d;
    bus.lane2_valid_in = l2v;
    bus.lane2_data_in  = l2d;
    @(posedge clk);
    #1;
    bus.lane1_valid_in = 1'b0;
    bus.lane2_valid_in = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic start(input int b, input int n);
    bus.start_in     = 1'b1;
    bus.base_addr_in = 6'(b);
    bus.num_elems_in = 6'(n);
    @(posedge clk);
    #1;
    bus.start_in = 1'b0;
  endtask

  task automatic drive_overlap(input int n);
    for (int j = 0; 2 * j - 1 < n; j++)
      step(2 * j < n, (2 * j < n) ? el[2 * j] : 16'h0,
           j >= 1, (j >= 1) ? el[2 * j - 1] : 16'h0);
  endtask

  task automatic drive_sparse(input int n);
    for (int i = 0; i < n; i++) begin
      if (i % 2 == 0) step(1'b1, el[i], 1'b0, 16'h0);
      else step(1'b0, 16'h0, 1'b1, el[i]);
      repeat ($urandom_range(0, 2)) idle();
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20 && bus.busy_out; i++) idle();
    chk({tag, "_busy"}, 64'(bus.busy_out), 64'd0);
    idle();
  endtask

  task automatic expect_writes(input string tag, input int b, input int n,
                               input int qs);
    int np = n / 2;
    int ne = np + n % 2;
    wr_t e;
    chk({tag, "_cnt"}, 64'(q.size() - qs), 64'(ne));
    for (int k = 0; k < ne; k++) begin
      if (k < np) e = '{6'((b + 2 * k) % 64), rl(el[2 * k]),
                        rl(el[2 * k + 1]), 1'b1, k == ne - 1};
      else e = '{6'((b + n - 1) % 64), rl(el[n - 1]), 16'h0, 1'b0, 1'b1};
      if (qs + k < q.size()) chk({tag, "_wr"}, 64'(q[qs + k]), 64'(e));
    end
  endtask

  task automatic run_xfer(input string tag, input int b, input int n,
                          input bit sparse);
    int qs = q.size();
    int dc = done_cnt;
    start(b, n);
    if (sparse) drive_sparse(n);
    else drive_overlap(n);
    wait_idle(tag);
    expect_writes(tag, b, n, qs);
    chk({tag, "_done"}, 64'(done_cnt - dc), 64'd1);
    chk({tag, "_err"}, 64'(bus.err_out), 64'd0);
  endtask

  initial begin
    int qs, dc;
    bus.start_in       = 1'b0;
    bus.base_addr_in   = '0;
    bus.num_elems_in   = '0;
    bus.lane1_valid_in = 1'b0;
    bus.lane1_data_in  = '0;
    bus.lane2_valid_in = 1'b0;
    bus.lane2_data_in  = '0;
    @(posedge clk);
    #1;
    chk("rst_outs", {bus.wr_valid_1_out, bus.wr_valid_2_out, bus.done_out,
        bus.busy_out, bus.err_out, bus.wr_addr_out, bus.wr_data_1_out,
        bus.wr_data_2_out}, 64'd0);
    rst = 1'b0;
    idle();

    start(8, 4);
    step(1'b1, A, 1'b0, 16'h0);
    step(1'b1, C, 1'b1, B);
    chk("n4_w0", {bus.wr_valid_1_out, bus.wr_valid_2_out, bus.wr_addr_out,
        bus.wr_data_1_out, bus.wr_data_2_out, bus.done_out},
        {1'b1, 1'b1, 6'd8, A, B, 1'b0});
    step(1'b0, 16'h0, 1'b1, D);
    chk("n4_w1", {bus.wr_valid_1_out, bus.wr_valid_2_out, bus.wr_addr_out,
        bus.wr_data_1_out, bus.wr_data_2_out, bus.done_out},
        {1'b1, 1'b1, 6'd10, C, D, 1'b1});
    idle();
    chk("n4_idle", {bus.wr_valid_1_out, bus.done_out, bus.busy_out,
        bus.err_out}, 64'd0);

    start(0, 3);
    step(1'b1, A, 1'b0, 16'h0);
    step(1'b1, C, 1'b1, B);
    chk("n3_w0", {bus.wr_valid_1_out, bus.wr_valid_2_out, bus.wr_addr_out,
        bus.wr_data_1_out, bus.wr_data_2_out, bus.done_out},
        {1'b1, 1'b1, 6'd0, A, B, 1'b0});
    idle();
    chk("n3_tail", {bus.wr_valid_1_out, bus.wr_valid_2_out, bus.wr_addr_out,
        bus.wr_data_1_out, bus.wr_data_2_out, bus.done_out},
        {1'b1, 1'b0, 6'd2, C, 16'h0, 1'b1});
    idle();
    chk("n3_busy", 64'(bus.busy_out), 64'd0);

    el[0] = 16'h0101; el[1] = 16'h0202; el[2] = 16'h0303; el[3] = 16'h0404;
    run_xfer("wrap", 62, 4, 1'b0);

    qs = q.size();
    el[0] = A; el[1] = B;
    start(0, 2);
    step(1'b0, 16'h0, 1'b1, 16'h5555);
    chk("stray_err", {bus.err_out, bus.busy_out, bus.wr_valid_1_out},
        {1'b1, 1'b1, 1'b0});
    drive_overlap(2);
    wait_idle("stray");
    expect_writes("stray", 0, 2, qs);
    chk("stray_sticky", 64'(bus.err_out), 64'd1);
    start(4, 2);
    chk("start_clr", 64'(bus.err_out), 64'd0);
    qs = q.size();
    drive_overlap(2);
    wait_idle("clean");
    expect_writes("clean", 4, 2, qs);
    chk("clean_err", 64'(bus.err_out), 64'd0);

    qs = q.size();
    start(20, 2);
    start(40, 2);
    chk("restart_err", 64'(bus.err_out), 64'd1);
    drive_overlap(2);
    wait_idle("restart");
    expect_writes("restart", 20, 2, qs);

    qs = q.size();
    dc = done_cnt;
    start(5, 0);
    chk("n0_done", {bus.done_out, bus.busy_out}, 64'b10);
    idle();
    chk("n0_pulse", 64'(bus.done_out), 64'd0);
    chk("n0_cnt", 64'(done_cnt - dc), 64'd1);
    step(1'b1, A, 1'b1, B);
    idle();
    chk("idle_lanes", {bus.err_out, 8'(q.size() - qs)}, 64'd0);

    qs = q.size();
    start(8, 4);
    step(1'b1, A, 1'b0, 16'h0);
    rst = 1'b1;
    #1;
    chk("midrst_outs", {bus.wr_valid_1_out, bus.wr_valid_2_out, bus.done_out,
        bus.busy_out, bus.err_out, bus.wr_addr_out, bus.wr_data_1_out,
        bus.wr_data_2_out}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 16'h0, 1'b1, B);
    idle();
    chk("midrst_nowr", 64'(q.size() - qs), 64'd0);
    el[0] = C; el[1] = D;
    run_xfer("postrst", 2, 2, 1'b0);

    el[0] = 16'hFFF0; el[1] = 16'h0010;
    run_xfer("relu", 12, 2, 1'b0);

    for (int t = 0; t < 40; t++) begin
      int n = $urandom_range(1, 12);
      for (int i = 0; i < 16; i++) el[i] = 16'($urandom);
      run_xfer($sformatf("rnd%0d", t), $urandom_range(0, 63), n,
               1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
